// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   op_e          : operation encoding presented on hilo_muldiv.op
//   state_e       : sequencing states of the HI/LO FSM
//   MD_XLEN       : default operand width
//   MD_DIV_STEPS  : default number of restoring-division iterations
//   cond_neg()    : two's-complement negate when the flag is set
package muldiv_pkg;

  localparam int MD_XLEN      = 32;
  localparam int MD_DIV_STEPS = MD_XLEN;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DIV_FIX = 2'd2
  } state_e;

  // Magnitude/sign conversion used on both the way into and out of the divider.
  function automatic logic [MD_XLEN-1:0] cond_neg(input logic [MD_XLEN-1:0] v,
                                                  input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// div_core: unsigned iterative restoring divider, one quotient bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch dividend/divisor and start a new division
//   dividend   : unsigned dividend (magnitude)
//   divisor    : unsigned divisor (magnitude, assumed non-zero)
//   quotient   : quotient, valid once the last step has been taken
//   remainder  : remainder, valid once the last step has been taken
//   last_step  : the step taken on the coming edge is the final one
module div_core
  import muldiv_pkg::*;
#(
  parameter int XLEN      = MD_XLEN,
  parameter int DIV_STEPS = MD_DIV_STEPS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last_step
);

  localparam int CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;     // dividend bits shift out the top, quotient bits shift in
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   counter;
  logic            active;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rem_shift = '0;
    diff      = '0;
    rem_shift = {rem, quo[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs};
  end

  assign last_step = active && (counter == CW'(DIV_STEPS - 1));
  assign quotient  = quo;
  assign remainder = rem;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      counter <= '0;
      active  <= 1'b0;
    end else if (load) begin
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
      counter <= '0;
      active  <= 1'b1;
    end else if (active) begin
      // Restoring step: keep the difference only when it did not go negative.
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= rem_shift[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      if (last_step) active  <= 1'b0;
      else           counter <= counter + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: architectural HI/LO register pair fed by the ALU product,
// an iterative divider and MTHI/MTLO writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, op  : operation request, accepted when start && ready
//   a, b       : rs (dividend / move data) and rt (divisor) operands
//   alu_total  : 2*XLEN product from the ALU, signedness already applied
//   ready/busy : busy while a division is in flight; ready = !busy
//   done       : one-cycle pulse after HI/LO updated by a multiply or divide
//   hi, lo     : current HI and LO
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN      = MD_XLEN,
  parameter int DIV_STEPS = MD_DIV_STEPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [2*XLEN-1:0] alu_total,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo
);

  state_e          state;
  logic            q_neg;
  logic            r_neg;

  logic            is_div;
  logic            signed_div;
  logic            div_load;
  logic [XLEN-1:0] dvd_mag;
  logic [XLEN-1:0] dvs_mag;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            last_step;

  assign busy       = (state != IDLE);
  assign ready      = !busy;
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_div = (op == OP_DIV);
  // Divide-by-zero completes in one cycle and never starts the core.
  assign div_load   = start && (state == IDLE) && is_div && (b != '0);
  assign dvd_mag    = cond_neg(a, signed_div && a[XLEN-1]);
  assign dvs_mag    = cond_neg(b, signed_div && b[XLEN-1]);

  div_core #(
    .XLEN      (XLEN),
    .DIV_STEPS (DIV_STEPS)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (quotient),
    .remainder (remainder),
    .last_step (last_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {hi, lo} <= alu_total;
                done     <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                  lo   <= '1;
                  hi   <= a;
                  done <= 1'b1;
                end else begin
                  // Quotient is negative iff operand signs differ; the
                  // remainder follows the dividend.
                  q_neg <= signed_div && (a[XLEN-1] ^ b[XLEN-1]);
                  r_neg <= signed_div && a[XLEN-1];
                  state <= DIV_RUN;
                end
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        DIV_RUN: begin
          if (last_step) state <= DIV_FIX;
        end
        DIV_FIX: begin
          lo    <= cond_neg(quotient, q_neg);
          hi    <= cond_neg(remainder, r_neg);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] alu_total;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Expected HI/LO before the current operation; used to confirm the pair
  // holds its value while a division runs.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .alu_total (alu_total),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single-cycle op; returns sampled at the negedge after the accept edge.
  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] prod);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; alu_total = prod;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  // Division: counts busy cycles, confirms HI/LO hold, optionally pokes an
  // MTLO request at busy cycle inj, then checks the written result.
  task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] elo,
                         input logic [31:0] ehi, input int inj);
    int   n;
    logic held;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n = 0; held = 1'b1;
    while (busy && n < 100) begin
      n++;
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0) held = 1'b0;
      if (n == inj) begin
        start = 1'b1; op = OP_MTLO; a = 32'h1234;
      end else begin
        start = 1'b0; op = OP_NOP;
      end
      @(negedge clk);
    end
    start = 1'b0; op = OP_NOP;
    check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    check({tag, "_hilo_held"}, {63'd0, held}, 64'd1);
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    check({tag, "_done_clr"}, {63'd0, done}, 64'd0);
    m_lo = elo;
    m_hi = ehi;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = OP_NOP; a = '0; b = '0; alu_total = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;

    // MULT 5*4 = 20
    do_op(OP_MULT, 32'd5, 32'd4, 64'd20);
    check("mult_hi", {32'd0, hi}, 64'd0);
    check("mult_lo", {32'd0, lo}, 64'd20);
    check("mult_done", {63'd0, done}, 64'd1);
    check("mult_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("mult_done_clr", {63'd0, done}, 64'd0);

    // MULTU 2111222333*2
    do_op(OP_MULTU, 32'd2111222333, 32'd2, 64'd4222444666);
    check("multu_hi", {32'd0, hi}, 64'd0);
    check("multu_lo", {32'd0, lo}, 64'd4222444666);
    m_hi = 32'd0; m_lo = 32'd4222444666;

    // Signed and unsigned division.
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, -1);
    run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1);

    // Divide by zero: single cycle.
    do_op(OP_DIVU, 32'd5, 32'd0, 64'd0);
    check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("div0_hi", {32'd0, hi}, 64'd5);
    check("div0_busy", {63'd0, busy}, 64'd0);
    check("div0_done", {63'd0, done}, 64'd1);
    m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;

    // MTLO during a division is dropped: -100/7 = -14 rem -2.
    run_div("div_inject", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 10);
    do_op(OP_MTHI, 32'hABCD, 32'd0, 64'd0);
    check("mthi_hi", {32'd0, hi}, 64'hABCD);
    check("mthi_lo", {32'd0, lo}, 64'hFFFF_FFF2);
    check("mthi_done", {63'd0, done}, 64'd0);
    do_op(OP_MTLO, 32'h5678, 32'd0, 64'd0);
    check("mtlo_hi", {32'd0, hi}, 64'hABCD);
    check("mtlo_lo", {32'd0, lo}, 64'h5678);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n = 0;
    while (busy && n < 15) begin
      n++;
      @(negedge clk);
    end
    check("rstmid_reached", 64'(n), 64'd15);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_hi", {32'd0, hi}, 64'd0);
    check("rstmid_lo", {32'd0, lo}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, -1);

    // Back-to-back: start held high, MULT accepted on the done cycle.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk);
    op = OP_MULT; alu_total = 64'h0000_0007_0000_0009;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", 64'(n), 64'd33);
    check("b2b_div_lo", {32'd0, lo}, 64'd10);
    check("b2b_div_hi", {32'd0, hi}, 64'd0);
    check("b2b_div_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    check("b2b_mult_hi", {32'd0, hi}, 64'd7);
    check("b2b_mult_lo", {32'd0, lo}, 64'd9);
    check("b2b_mult_done", {63'd0, done}, 64'd1);
    check("b2b_mult_busy", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Holds the architectural HI/LO register pair and sits directly downstream of the ALU.
- Captures the ALU's 64-bit multiply product (signed/unsigned mult ops) into HI/LO.
- Performs iterative 32-bit signed/unsigned division and handles MTHI/MTLO writes.
- Exposes HI/LO for MFHI/MFLO, plus a busy flag the pipeline uses to stall HI/LO readers.

Parameters:
- XLEN, 32, operand width; HI and LO are XLEN each and the product input is 2*XLEN.
- DIV_STEPS, XLEN, number of restoring-division iterations.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to accept op this cycle.
- op  in  3  operation: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, others treated as NOP.
- a  in  XLEN  rs operand: dividend, or MTHI/MTLO data.
- b  in  XLEN  rt operand (divisor).
- alu_total  in  2*XLEN  ALU product, already computed with signedness matching op.
- ready  out  1  equals !busy; op accepted only when start && ready.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse the cycle after HI/LO updated by MULT/MULTU/DIV/DIVU.
- hi  out  XLEN  current HI.
- lo  out  XLEN  current LO.

Behaviour:
- Reset (async, any state, including mid-division): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0; any partial quotient/remainder is discarded.
- States:
  - IDLE: accepts ops.
  - DIV_RUN: one iteration per cycle.
  - DIV_FIX: sign fix-up and HI/LO write.
- Accept = start && state==IDLE && op valid non-NOP. start while busy is ignored with no side effects; the op is not queued.
- MULT/MULTU on accept edge: {hi,lo} <= alu_total; done=1 next cycle; state stays IDLE. The block does not check signedness; alu_total is trusted.
- MTHI/MTLO on accept edge: hi<=a or lo<=a only; the other register is untouched; done stays 0.
- DIV/DIVU with b!=0, timing:
  - Accept edge E0 latches the operand magnitudes (abs for DIV, raw for DIVU), the quotient/remainder sign flags and counter=0, then enters DIV_RUN.
  - Edges E1..E32 each run one restoring step (shift remainder left, subtract divisor, set quotient bit if non-negative).
  - At counter==DIV_STEPS-1 the state moves to DIV_FIX.
  - Edge E33 writes lo=quotient and hi=remainder with signs applied (quotient negative iff operand signs differ, remainder takes the dividend's sign), then returns to IDLE.
  - busy is high for exactly 33 cycles (E0 to E33); done pulses in the cycle after E33.
  - hi/lo hold their old values throughout the division.
- DIV INT_MIN / -1: lo=0x80000000, hi=0 (natural two's-complement wrap, no trap).
- Divide by zero (b==0), DIV or DIVU: single cycle, no busy. On the accept edge lo<=0xFFFFFFFF and hi<=a; done pulses next cycle.
- A new op may be accepted on the same edge that done is asserted (state already IDLE).
- Arithmetic is modulo 2^XLEN; no overflow flags.

Decomposition:
- muldiv_pkg: op encoding enum (NOP..MTLO), state enum (IDLE, DIV_RUN, DIV_FIX), DIV_STEPS constant, and a helper function for conditional two's-complement negate.
- One sub-module, div_core: unsigned iterative restoring divider.
  - Inputs: clk, rst_n, load, dividend, divisor.
  - Outputs: quotient, remainder, last_step.
  - hilo_muldiv owns the FSM, sign handling and HI/LO.

Test Plan:
- Multiply capture: start op=MULT, alu_total=20 (a=5, b=4) → next cycle hi=0, lo=20, done=1 for one cycle, busy never high. Then MULTU with alu_total=4222444666 (2111222333*2) → hi=0, lo=4222444666.
- Signed division: DIV a=-7, b=2 → busy high 33 cycles, hi/lo unchanged meanwhile; then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done pulse. DIVU a=100, b=7 → lo=14, hi=2.
- Edge cases:
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU a=5, b=0 → one cycle later lo=0xFFFFFFFF, hi=5, busy stays 0.
- Busy rejection: during DIV, assert start op=MTLO a=0x1234 at cycle 10 → ignored; final lo is the quotient, not 0x1234. MTHI a=0xABCD after done → hi=0xABCD, lo unchanged.
- Reset mid-op: DIVU 100/7, deassert rst_n at cycle 15 → hi=lo=0, busy=0 immediately (async). After release, DIVU 9/3 → lo=3, hi=0 after 33 busy cycles.
- Back-to-back: start DIVU held high through done with the next op=MULT → MULT accepted on the done cycle; hi/lo reflect the product one cycle later.
